// File: rtl/instr_mem_loadable_if.sv
// Load and fetch port bundle for the loadable instruction memory.
// The requester (master) drives loads and fetch requests; the memory (slave) answers.
interface instr_mem_loadable_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_busy;
  logic              ld_done;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_halt;

  modport master (
    output ld_start, ld_valid, ld_data, fetch_req, fetch_addr,
    input  ld_busy, ld_done, fetch_ready, fetch_valid, fetch_data, fetch_halt
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, fetch_req, fetch_addr,
    output ld_busy, ld_done, fetch_ready, fetch_valid, fetch_data, fetch_halt
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a sequential program-load port and a single-cycle
// pipelined fetch port; fetches are blocked while a load is in progress.
module instr_mem_loadable #(
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      ADDR_W   = 5,
  parameter int unsigned      OPC_W    = 5,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(5'b10000)
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_mem_loadable_if.slave  bus
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ld_done_q, ld_done_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_halt_q, fetch_halt_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic              mem_we_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_word_c = mem_q[bus.fetch_addr];

  // Next-state: load sequencing plus fetch acceptance (only in RUN).
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    ld_done_d     = 1'b0;
    mem_we_c      = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_halt_d  = 1'b0;
    fetch_data_d  = fetch_data_q;

    unique case (state_q)
      RUN: begin
        if (bus.ld_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (bus.ld_start) begin
          ptr_d = '0;
        end else if (bus.ld_valid) begin
          mem_we_c = 1'b1;
          if (ptr_q == LAST) begin
            state_d   = RUN;
            ld_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
    endcase

    if (bus.fetch_req && (state_q == RUN)) begin
      fetch_valid_d = 1'b1;
      fetch_data_d  = rd_word_c;
      fetch_halt_d  = (rd_word_c[DATA_W-1 -: OPC_W] == HALT_OPC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ptr_q         <= '0;
      ld_done_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_halt_q  <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ld_done_q     <= ld_done_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_halt_q  <= fetch_halt_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  // Storage is never reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      mem_q[ptr_q] <= bus.ld_data;
    end
  end

  assign bus.ld_busy     = (state_q == LOAD);
  assign bus.fetch_ready = (state_q == RUN);
  assign bus.ld_done     = ld_done_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_halt  = fetch_halt_q;
  assign bus.fetch_data  = fetch_data_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomized plus directed bench for instr_mem_loadable against a
// transaction-level model of loads, aborts and fetches.
module tb_instr_mem_loadable;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;
  localparam logic [31:0] HALT_WORD = 32'b10000000100010100001000000000000;

  logic clk;
  logic rst;

  instr_mem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_loadable #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(5), .HALT_OPC(5'b10000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit          m_loading = 1'b0;
  int          m_ptr     = 0;
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          e_valid = 1'b0;
  bit          e_halt  = 1'b0;
  bit          e_done  = 1'b0;
  logic [31:0] e_data  = '0;
  bit          e_data_known = 1'b0;
  int          done_pulses  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit v, input logic [31:0] d,
                       input bit q, input logic [4:0] a);
    rst            = r;
    bus.ld_start   = s;
    bus.ld_valid   = v;
    bus.ld_data    = d;
    bus.fetch_req  = q;
    bus.fetch_addr = a;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_step();
    int a;
    if (rst) begin
      m_loading = 1'b0; m_ptr = 0;
      e_valid = 1'b0; e_halt = 1'b0; e_done = 1'b0;
      e_data = '0; e_data_known = 1'b1;
      return;
    end
    e_done = 1'b0;
    if (bus.fetch_req && !m_loading) begin
      a = int'(bus.fetch_addr);
      e_valid = 1'b1;
      e_data_known = m_known[a];
      e_data = m_mem[a];
      e_halt = m_known[a] && (m_mem[a][31:27] == 5'd16);
    end else begin
      e_valid = 1'b0;
      e_halt  = 1'b0;
    end
    if (!m_loading) begin
      if (bus.ld_start) begin
        m_loading = 1'b1; m_ptr = 0;
      end
    end else if (bus.ld_start) begin
      m_ptr = 0;
    end else if (bus.ld_valid) begin
      m_mem[m_ptr] = bus.ld_data;
      m_known[m_ptr] = 1'b1;
      if (m_ptr == DEPTH - 1) begin
        e_done = 1'b1; m_loading = 1'b0; done_pulses++;
      end else begin
        m_ptr++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("ld_busy", 32'(bus.ld_busy), 32'(m_loading));
    chk("fetch_ready", 32'(bus.fetch_ready), 32'(!m_loading));
    chk("ld_done", 32'(bus.ld_done), 32'(e_done));
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(e_valid));
    if (e_data_known) begin
      chk("fetch_halt", 32'(bus.fetch_halt), 32'(e_halt));
      chk("fetch_data", bus.fetch_data, e_data);
    end
  endtask

  task automatic full_load(input int kind);
    logic [31:0] d;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      d = (kind == 1 && i == 19) ? HALT_WORD : 32'(i * 3);
      drive(1'b0, 1'b0, 1'b1, d, 1'b0, 5'd0);
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    int pulses_before;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
    tick();
    tick();

    // Load addr*3 and check a single completion pulse
    pulses_before = done_pulses;
    full_load(0);
    chk("load_done_count", 32'(done_pulses - pulses_before), 32'd1);

    // Back-to-back fetches of 0,1,2
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'(i));
      tick();
      chk("b2b_data", bus.fetch_data, 32'(i * 3));
    end
    idle();
    tick();
    tick();

    // Halt word at address 19
    full_load(1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd19);
    tick();
    chk("halt_data", bus.fetch_data, HALT_WORD);
    chk("halt_flag", 32'(bus.fetch_halt), 32'd1);
    idle();
    tick();

    // Fetch coincident with ld_start, then a fetch held through the whole load
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd19);
    tick();
    chk("start_edge_fetch", bus.fetch_data, HALT_WORD);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 5'd7);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd7);
    tick();
    chk("held_fetch_valid", 32'(bus.fetch_valid), 32'd1);
    idle();
    tick();

    // Abort after 10 words; rst overrides start/valid/fetch in the same cycle
    pulses_before = done_pulses;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'(1000 + i), 1'b0, 5'd0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 32'hdead_beef, 1'b1, 5'd3);
    tick();
    chk("abort_no_done", 32'(done_pulses - pulses_before), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'(i));
      tick();
    end
    idle();
    tick();

    // Restart at ptr==5 with a coincident ld_valid that must be dropped
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'(500 + i), 1'b0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 32'hbeef_0000, 1'b0, 5'd0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'(700 + i), 1'b0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd0);
    tick();
    chk("restart_addr0", bus.fetch_data, 32'd700);
    idle();
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 300) == 0, ($urandom % 100) == 0, $urandom_range(0, 1) == 1,
            $urandom, $urandom_range(0, 1) == 1, 5'($urandom));
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
